// File: rtl/csa_final_adder.sv
// csa_final_adder
//   Resolves the redundant (ps, pc) pair from csa_tree into a binary sum,
//   out_sum = ps + 2*pc, adding CHUNK bits per clock so the carry path per
//   cycle is only CHUNK bits long.
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous reset, active-low
//   in_valid  operands on ps/pc are valid
//   in_ready  block accepts operands this cycle (IDLE and not in reset)
//   ps        partial sum, WIDTH bits
//   pc        partial carry, WIDTH bits, weight 2
//   out_valid out_sum holds a completed result
//   out_ready consumer takes the result this cycle
//   out_sum   ps + 2*pc, WIDTH+2 bits
module csa_final_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ps,
  input  logic [WIDTH-1:0] pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_sum
);

  localparam int OUT_W  = WIDTH + 2;
  localparam int STEPS  = (OUT_W + CHUNK - 1) / CHUNK;
  localparam int PAD_W  = STEPS * CHUNK;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned CHUNK_U = CHUNK;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic [PAD_W-1:0]  a_q, b_q;
  logic [OUT_W-1:0]  sum_q;
  logic [STEP_W-1:0] step;
  logic              carry;

  logic [PAD_W-1:0]  a_ext, b_ext;
  logic [CHUNK-1:0]  a_chunk, b_chunk, chunk_sum;
  logic              chunk_cout;
  logic [OUT_W-1:0]  chunk_placed;
  int unsigned       shift_amt;
  logic              accept, last_step;

  // Operands zero-padded to a whole number of chunks.
  assign a_ext = PAD_W'({2'b00, ps});
  assign b_ext = PAD_W'({1'b0, pc, 1'b0});

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign out_sum   = sum_q;

  assign accept    = in_valid && in_ready;
  assign last_step = (step == STEP_W'(STEPS - 1));

  // Chunk select and placement by shifting keeps every index constant-width;
  // sum_q is cleared at acceptance and each chunk is written exactly once,
  // so OR-ing the placed chunk is equivalent to a part-select write. Bits of
  // the top chunk beyond OUT_W are always zero and simply drop off.
  always_comb begin
    shift_amt    = 32'(step) * CHUNK_U;
    a_chunk      = CHUNK'(a_q >> shift_amt);
    b_chunk      = CHUNK'(b_q >> shift_amt);
    {chunk_cout, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk}
                            + {{CHUNK{1'b0}}, carry};
    chunk_placed = OUT_W'({{(PAD_W-CHUNK){1'b0}}, chunk_sum} << shift_amt);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      step  <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= a_ext;
            b_q   <= b_ext;
            sum_q <= '0;
            step  <= '0;
            carry <= 1'b0;
          end
        end
        BUSY: begin
          sum_q <= sum_q | chunk_placed;
          carry <= chunk_cout;
          step  <= step + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
